// File: rtl/vector_exec_unit.sv
// vector_exec_unit: multi-cycle vector ALU.
// Accepts one operation per in_valid/in_ready handshake. It processes LANES elements per
// clock over BEATS = NUM_ELEM/LANES beats, then holds the full result until the consumer
// takes it through out_valid/out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operation request valid
//   in_ready   unit accepts a request this cycle
//   op         000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 111 REDSUM (110 -> 0)
//   src_a      operand A, element i at [i*ELEM_WIDTH +: ELEM_WIDTH]
//   src_b      operand B, same packing
//   use_scalar replace every B element by scalar_b
//   scalar_b   broadcast scalar
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   result     vector result
//   zero       result == 0; meaningful only while out_valid is high
//   busy       unit not idle
// NUM_ELEM must be a multiple of LANES.
module vector_exec_unit #(
  parameter int unsigned NUM_ELEM   = 8,
  parameter int unsigned ELEM_WIDTH = 32,
  parameter int unsigned LANES      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2:0]                       op,
  input  logic [NUM_ELEM*ELEM_WIDTH-1:0]   src_a,
  input  logic [NUM_ELEM*ELEM_WIDTH-1:0]   src_b,
  input  logic                             use_scalar,
  input  logic [ELEM_WIDTH-1:0]            scalar_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEM*ELEM_WIDTH-1:0]   result,
  output logic                             zero,
  output logic                             busy
);

  localparam int unsigned RegWidth = NUM_ELEM * ELEM_WIDTH;
  localparam int unsigned Beats    = NUM_ELEM / LANES;
  localparam int unsigned BeatW    = (Beats > 1) ? $clog2(Beats) : 1;

  localparam logic [2:0] OpAdd    = 3'b000;
  localparam logic [2:0] OpSub    = 3'b001;
  localparam logic [2:0] OpAnd    = 3'b010;
  localparam logic [2:0] OpOr     = 3'b011;
  localparam logic [2:0] OpXor    = 3'b100;
  localparam logic [2:0] OpSlt    = 3'b101;
  localparam logic [2:0] OpRedsum = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [RegWidth-1:0]     a_q, a_d;
  logic [RegWidth-1:0]     b_q, b_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic [ELEM_WIDTH-1:0]   acc_q, acc_d;
  logic [RegWidth-1:0]     result_q, result_d;
  logic                    zero_q, zero_d;

  logic                    accept;
  logic                    last_beat;
  logic [RegWidth-1:0]     b_eff;
  logic [ELEM_WIDTH-1:0]   elem_a, elem_b, lane_sum;
  int unsigned             idx;

  // Per-element operation; REDSUM and the undefined encoding produce 0 here, the
  // reduction itself is carried in the accumulator.
  function automatic logic [ELEM_WIDTH-1:0] elem_op(input logic [2:0]            o,
                                                    input logic [ELEM_WIDTH-1:0] a,
                                                    input logic [ELEM_WIDTH-1:0] b);
    logic [ELEM_WIDTH-1:0] r;
    r = '0;
    case (o)
      OpAdd:   r = a + b;
      OpSub:   r = a - b;
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpSlt:   r = {{(ELEM_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    b_eff     = use_scalar ? {NUM_ELEM{scalar_b}} : src_b;
    last_beat = (beat_q == BeatW'(Beats - 1));
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      beat_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      beat_q   <= beat_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StExec;
      StExec: if (last_beat) state_d = StDone;
      StDone: begin
        if (out_ready) state_d = in_valid ? StExec : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs. In DONE the unit can take a new request only in the cycle the result leaves.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      StExec: ;
      StDone: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
    endcase
    accept = in_valid && in_ready;
    result = result_q;
    zero   = zero_q;
  end

  // Datapath: capture on accept, one beat of LANES elements per EXEC cycle.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    beat_d   = beat_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    lane_sum = '0;
    elem_a   = '0;
    elem_b   = '0;
    idx      = 0;
    if (accept) begin
      op_d   = op;
      a_d    = src_a;
      b_d    = b_eff;
      beat_d = '0;
      acc_d  = '0;
    end else if (state_q == StExec) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        idx      = 32'(beat_q) * LANES + l;
        elem_a   = a_q[idx*ELEM_WIDTH +: ELEM_WIDTH];
        elem_b   = b_q[idx*ELEM_WIDTH +: ELEM_WIDTH];
        result_d[idx*ELEM_WIDTH +: ELEM_WIDTH] = elem_op(op_q, elem_a, elem_b);
        lane_sum = lane_sum + elem_a + elem_b;
      end
      acc_d  = acc_q + lane_sum;
      beat_d = beat_q + BeatW'(1);
      if (last_beat) begin
        // The reduction result replaces the whole vector once all beats are summed.
        if (op_q == OpRedsum) begin
          result_d                   = '0;
          result_d[ELEM_WIDTH-1:0]   = acc_d;
        end
        zero_d = (result_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_vector_exec_unit.sv
// Bench for vector_exec_unit: three instances (LANES = 2, 1, 8) share one stimulus stream.
// An abstract per-instance model (countdown to result, result computed over whole vectors)
// is checked against every instance on each falling edge; directed tests add literal checks.
module tb_vector_exec_unit;

  localparam int NE = 8;
  localparam int EW = 32;
  localparam int RW = NE * EW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [2:0]    op;
  logic [RW-1:0] src_a, src_b;
  logic          use_scalar;
  logic [EW-1:0] scalar_b;
  logic          out_ready;

  logic          ir0, ir1, ir2, ov0, ov1, ov2, z0, z1, z2, bz0, bz1, bz2;
  logic [RW-1:0] r0, r1, r2;

  int total = 0;
  int bad   = 0;

  int            beats [3] = '{4, 8, 1};
  bit            m_busy [3];
  bit            m_done [3];
  bit            m_zero [3];
  int            m_cnt [3];
  logic [RW-1:0] m_res [3];

  vector_exec_unit #(.NUM_ELEM(NE), .ELEM_WIDTH(EW), .LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .op(op), .src_a(src_a),
    .src_b(src_b), .use_scalar(use_scalar), .scalar_b(scalar_b), .out_valid(ov0),
    .out_ready(out_ready), .result(r0), .zero(z0), .busy(bz0)
  );
  vector_exec_unit #(.NUM_ELEM(NE), .ELEM_WIDTH(EW), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .op(op), .src_a(src_a),
    .src_b(src_b), .use_scalar(use_scalar), .scalar_b(scalar_b), .out_valid(ov1),
    .out_ready(out_ready), .result(r1), .zero(z1), .busy(bz1)
  );
  vector_exec_unit #(.NUM_ELEM(NE), .ELEM_WIDTH(EW), .LANES(8)) u_l8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .op(op), .src_a(src_a),
    .src_b(src_b), .use_scalar(use_scalar), .scalar_b(scalar_b), .out_valid(ov2),
    .out_ready(out_ready), .result(r2), .zero(z2), .busy(bz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Whole-vector reference result.
  function automatic logic [RW-1:0] model(input logic [2:0] o, input logic [RW-1:0] a,
                                          input logic [RW-1:0] b, input logic us,
                                          input logic [EW-1:0] sb);
    logic [RW-1:0] res;
    logic [EW-1:0] ea, eb, r, acc;
    res = '0;
    acc = '0;
    for (int i = 0; i < NE; i++) begin
      ea = a[i*EW +: EW];
      eb = us ? sb : b[i*EW +: EW];
      case (o)
        3'd0: r = ea + eb;
        3'd1: r = ea - eb;
        3'd2: r = ea & eb;
        3'd3: r = ea | eb;
        3'd4: r = ea ^ eb;
        3'd5: r = ($signed(ea) < $signed(eb)) ? 32'd1 : 32'd0;
        default: r = '0;
      endcase
      acc = acc + ea + eb;
      res[i*EW +: EW] = r;
    end
    if (o == 3'd7) begin
      res = '0;
      res[EW-1:0] = acc;
    end
    return res;
  endfunction

  task automatic check_dut(input int k, input logic ov, input logic ir, input logic bz,
                           input logic z, input logic [RW-1:0] r);
    string p;
    p = $sformatf("dut%0d", k);
    chk({p, " out_valid"}, RW'(ov), RW'(m_done[k]));
    chk({p, " busy"}, RW'(bz), RW'(m_busy[k]));
    chk({p, " in_ready"}, RW'(ir), RW'(!m_busy[k] || (m_done[k] && out_ready)));
    if (!rst) begin
      chk({p, " reset result"}, r, '0);
      chk({p, " reset zero"}, RW'(z), '0);
    end else if (m_done[k]) begin
      chk({p, " result"}, r, m_res[k]);
      chk({p, " zero"}, RW'(z), RW'(m_zero[k]));
    end
  endtask

  // Compare process: check, then advance the model by the upcoming rising edge.
  always @(negedge clk) begin
    bit acc_now;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        m_busy[k] = 0;
        m_done[k] = 0;
        m_cnt[k]  = 0;
      end
    end
    check_dut(0, ov0, ir0, bz0, z0, r0);
    check_dut(1, ov1, ir1, bz1, z1, r1);
    check_dut(2, ov2, ir2, bz2, z2, r2);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        acc_now = in_valid && (!m_busy[k] || (m_done[k] && out_ready));
        if (m_done[k]) begin
          if (out_ready) begin
            m_done[k] = 0;
            m_busy[k] = 0;
          end
        end else if (m_busy[k]) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) m_done[k] = 1;
        end
        if (acc_now) begin
          m_busy[k] = 1;
          m_done[k] = 0;
          m_cnt[k]  = beats[k];
          m_res[k]  = model(op, src_a, src_b, use_scalar, scalar_b);
          m_zero[k] = (m_res[k] == '0);
        end
      end
    end
  end

  // Present a request for one edge, then scramble the inputs (don't-care after capture).
  task automatic send(input logic [2:0] o, input logic [RW-1:0] a, input logic [RW-1:0] b,
                      input logic us, input logic [EW-1:0] sb);
    op = o; src_a = a; src_b = b; use_scalar = us; scalar_b = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    op         = 3'($urandom());
    src_a      = {8{$urandom()}};
    src_b      = {8{$urandom()}};
    scalar_b   = $urandom();
    use_scalar = ~us;
  endtask

  // Edges from the accepting edge until each instance raises out_valid.
  task automatic measure();
    int lat [3];
    lat = '{0, 0, 0};
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ov0 && lat[0] == 0) lat[0] = n;
      if (ov1 && lat[1] == 0) lat[1] = n;
      if (ov2 && lat[2] == 0) lat[2] = n;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    chk("latency lanes2", RW'(lat[0]), RW'(4));
    chk("latency lanes1", RW'(lat[1]), RW'(8));
    chk("latency lanes8", RW'(lat[2]), RW'(1));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [RW-1:0] va, vb, saved;

  initial begin
    rst = 1'b0; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
    use_scalar = 1'b0; scalar_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NE; i++) begin
      va[i*EW +: EW] = i;
      vb[i*EW +: EW] = 10 * i;
    end

    // Reset in the middle of execution.
    send(3'd0, va, vb, 1'b0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst out_valid", RW'(ov0), '0);
    chk("rst result", r1, '0);
    chk("rst in_ready", RW'(ir0), RW'(1));
    chk("rst busy", RW'(bz1), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no result after rst", RW'({ov0, ov1, ov2}), '0);

    // ADD ramp.
    send(3'd0, va, vb, 1'b0, '0);
    measure();
    for (int i = 0; i < NE; i++)
      chk($sformatf("add elem%0d", i), RW'(r0[i*EW +: EW]), RW'(11 * i));
    chk("add zero", RW'(z0), '0);
    release_out();

    // SUB with scalar broadcast to zero, then underflow.
    send(3'd1, {8{32'd5}}, vb, 1'b1, 32'd5);
    measure();
    chk("sub scalar result", r0, '0);
    chk("sub scalar zero", RW'(z0), RW'(1));
    release_out();
    send(3'd1, '0, {8{32'd1}}, 1'b0, '0);
    measure();
    chk("sub wrap result", r0, {RW{1'b1}});
    chk("sub wrap zero", RW'(z0), '0);
    release_out();

    // SLT signed.
    va = {8{32'h1234_5678}};
    vb = va;
    va[31:0] = 32'hFFFF_FFFF; vb[31:0] = 32'd0;
    va[63:32] = 32'd1;        vb[63:32] = 32'hFFFF_FFFF;
    send(3'd5, va, vb, 1'b0, '0);
    measure();
    chk("slt result", r2, RW'(1));
    release_out();

    // REDSUM.
    for (int i = 0; i < NE; i++) va[i*EW +: EW] = i + 1;
    send(3'd7, va, '0, 1'b0, '0);
    measure();
    chk("redsum result", r1, RW'(36));
    chk("redsum zero", RW'(z1), '0);
    release_out();
    send(3'd7, {8{32'h8000_0000}}, '0, 1'b0, '0);
    measure();
    chk("redsum wrap result", r0, '0);
    chk("redsum wrap zero", RW'(z2), RW'(1));
    release_out();

    // Bitwise ops and the undefined encoding.
    va = {32'hF0F0_0000, 32'h0F0F_FFFF, 32'hAAAA_5555, 32'h1, 32'h0, 32'hDEAD_BEEF,
          32'h8000_0001, 32'h7FFF_FFFF};
    send(3'd4, va, '0, 1'b1, 32'hFFFF_0000);
    measure();
    chk("xor scalar elem0", RW'(r0[31:0]), RW'(32'h8000_FFFF));
    release_out();
    send(3'd2, va, {8{32'h0000_FFFF}}, 1'b0, '0);
    measure();
    release_out();
    send(3'd6, va, va, 1'b0, '0);
    measure();
    chk("op110 result", r0, '0);
    release_out();

    // Backpressure, then back-to-back accept from DONE.
    send(3'd3, va, {8{32'h0101_0101}}, 1'b0, '0);
    measure();
    saved = r0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      chk("hold result", r0, saved);
      chk("hold in_ready", RW'({ir0, ir1, ir2}), '0);
    end
    for (int i = 0; i < NE; i++) begin
      va[i*EW +: EW] = i;
      vb[i*EW +: EW] = 10 * i;
    end
    out_ready = 1'b1;
    send(3'd0, va, vb, 1'b0, '0);
    out_ready = 1'b0;
    measure();
    chk("b2b elem7", RW'(r1[7*EW +: EW]), RW'(77));
    release_out();

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
